// File: rtl/vga_timing_gen.sv
// Raster timing generator for a 640x480 @ 60 Hz display path.
// Counts pixel columns and lines, and produces active-low sync pulses, a
// blanking flag and a start-of-frame strobe. Every output is registered and
// derived from the next-state counter values. As a result, the sync and blank
// flags line up with the hcount/vcount they describe.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic        ce,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        HS,
    output logic        VS,
    output logic        blank,
    output logic        frame_start
);

    localparam int unsigned CW          = 11;
    localparam int unsigned H_TOTAL     = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL     = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_BEG  = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END  = H_VISIBLE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_BEG  = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END  = V_VISIBLE + V_FP + V_SYNC;

    logic          h_wrap;
    logic          v_wrap;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic          hs_next;
    logic          vs_next;
    logic          blank_next;

    // Next counter values. The >= compare also folds any out-of-range value back to 0.
    always_comb begin
        h_wrap     = (hcount >= CW'(H_TOTAL - 1));
        v_wrap     = (vcount >= CW'(V_TOTAL - 1));
        h_next     = h_wrap ? '0 : hcount + CW'(1);
        v_next     = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : vcount + CW'(1);
        end
        hs_next    = !((h_next >= CW'(H_SYNC_BEG)) && (h_next < CW'(H_SYNC_END)));
        vs_next    = !((v_next >= CW'(V_SYNC_BEG)) && (v_next < CW'(V_SYNC_END)));
        blank_next = (h_next >= CW'(H_VISIBLE)) || (v_next >= CW'(V_VISIBLE));
    end

    // Output registers. They advance only on ce edges; frame_start is a single ce-qualified pulse.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            HS          <= 1'b1;
            VS          <= 1'b1;
            blank       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (ce) begin
                hcount      <= h_next;
                vcount      <= v_next;
                HS          <= hs_next;
                VS          <= vs_next;
                blank       <= blank_next;
                frame_start <= h_wrap && v_wrap;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.
// The instance "dut" uses the real 640x480 timing and covers the line-level behaviour.
// The instance "dut_s" uses a shrunken raster of 15x8 positions (120 per frame), so that
// frame-level behaviour fits in a short run.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst, ce, rst_s, ce_s;
    logic [10:0] hcount, vcount, hcount_s, vcount_s;
    logic        hs, vs, blank, fs;
    logic        hs_s, vs_s, blank_s, fs_s;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .pixel_clk(clk), .rst(rst), .ce(ce),
        .hcount(hcount), .vcount(vcount),
        .HS(hs), .VS(vs), .blank(blank), .frame_start(fs)
    );

    // Small raster: HS low at h 10..12; VS low at v 5..6; visible region 8x4.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .pixel_clk(clk), .rst(rst_s), .ce(ce_s),
        .hcount(hcount_s), .vcount(vcount_s),
        .HS(hs_s), .VS(vs_s), .blank(blank_s), .frame_start(fs_s)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned adv;
        int unsigned h;
        int unsigned v;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance n clock edges and sample 1 time unit after the last one.
    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int hs_low, hs_first_low, hs_back_high, blank_rise;
        int fs_count, fs_pos0, fs_pos1, vs_low, vs_first_h, vs_first_v, blank0, max_h, max_v;

        // Cumulative ce cycles after reset release: 1,639,640,655,656,751,752,799,800,1440
        vecs[0] = '{1,   1,   0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{638, 639, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1,   640, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{15,  655, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1,   656, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{95,  751, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1,   752, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{47,  799, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{1,   0,   1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{640, 640, 1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; ce = 1'b0; rst_s = 1'b1; ce_s = 1'b0;
        tick(2);
        check("rst_hcount", 32'(hcount), 0);
        check("rst_vcount", 32'(vcount), 0);
        check("rst_hs", 32'(hs), 1);
        check("rst_vs", 32'(vs), 1);
        check("rst_blank", 32'(blank), 0);
        check("rst_fs", 32'(fs), 0);

        // Table-driven line checks on the full-size raster
        rst = 1'b0; ce = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(vecs[i].adv);
            check($sformatf("vec%0d_hcount", i), 32'(hcount), 32'(vecs[i].h));
            check($sformatf("vec%0d_vcount", i), 32'(vcount), 32'(vecs[i].v));
            check($sformatf("vec%0d_hs", i), 32'(hs), 32'(vecs[i].hs));
            check($sformatf("vec%0d_vs", i), 32'(vs), 32'(vecs[i].vs));
            check($sformatf("vec%0d_blank", i), 32'(blank), 32'(vecs[i].bl));
            check($sformatf("vec%0d_fs", i), 32'(fs), 32'(vecs[i].fs));
        end

        // Full-line sweep of line 2 (starts at h=0, v=2)
        tick(160);
        check("sweep_start_h", 32'(hcount), 0);
        check("sweep_start_v", 32'(vcount), 2);
        hs_low = 0; hs_first_low = -1; hs_back_high = -1; blank_rise = -1;
        for (int k = 0; k < 800; k++) begin
            tick(1);
            if (!hs) begin
                hs_low++;
                if (hs_first_low < 0) hs_first_low = int'(hcount);
            end else if (hs_first_low >= 0 && hs_back_high < 0) begin
                hs_back_high = int'(hcount);
            end
            if (blank && blank_rise < 0) blank_rise = int'(hcount);
        end
        check("sweep_hs_low_cycles", 32'(hs_low), 96);
        check("sweep_hs_first_low_h", 32'(hs_first_low), 656);
        check("sweep_hs_high_again_h", 32'(hs_back_high), 752);
        check("sweep_blank_rise_h", 32'(blank_rise), 640);
        check("sweep_end_v", 32'(vcount), 3);

        // ce pattern 1,0,0,1 starting from hcount=10
        tick(10);
        check("ce_start_h", 32'(hcount), 10);
        ce = 1'b1; tick(1); check("ce_seq0_h", 32'(hcount), 11);
        ce = 1'b0; tick(1); check("ce_seq1_h", 32'(hcount), 11);
        tick(1);            check("ce_seq2_h", 32'(hcount), 11);
        ce = 1'b1; tick(1); check("ce_seq3_h", 32'(hcount), 12);

        // Asynchronous reset mid-line while HS is low
        tick(688);
        check("midline_h", 32'(hcount), 700);
        check("midline_hs", 32'(hs), 0);
        #2 rst = 1'b1;
        #1;
        check("arst_hcount", 32'(hcount), 0);
        check("arst_vcount", 32'(vcount), 0);
        check("arst_hs", 32'(hs), 1);
        check("arst_blank", 32'(blank), 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("arst_resume_h", 32'(hcount), 1);
        ce = 1'b0;

        // Small raster: 359 continuous cycles, that is, almost 3 frames
        rst_s = 1'b0; ce_s = 1'b1;
        fs_count = 0; fs_pos0 = -1; fs_pos1 = -1;
        vs_low = 0; vs_first_h = -1; vs_first_v = -1; blank0 = 0; max_h = 0; max_v = 0;
        for (int k = 1; k <= 359; k++) begin
            tick(1);
            if (fs_s) begin
                fs_count++;
                if (fs_pos0 < 0) fs_pos0 = k;
                else if (fs_pos1 < 0) fs_pos1 = k;
            end
            if (int'(hcount_s) > max_h) max_h = int'(hcount_s);
            if (int'(vcount_s) > max_v) max_v = int'(vcount_s);
            if (k <= 120) begin
                if (!vs_s) begin
                    vs_low++;
                    if (vs_first_h < 0) begin
                        vs_first_h = int'(hcount_s);
                        vs_first_v = int'(vcount_s);
                    end
                end
                if (!blank_s) blank0++;
            end
        end
        check("frame_fs_count", 32'(fs_count), 2);
        check("frame_fs_pos0", 32'(fs_pos0), 120);
        check("frame_fs_pos1", 32'(fs_pos1), 240);
        check("frame_vs_low_cycles", 32'(vs_low), 30);
        check("frame_vs_first_h", 32'(vs_first_h), 0);
        check("frame_vs_first_v", 32'(vs_first_v), 5);
        check("frame_blank0_cycles", 32'(blank0), 32);
        check("frame_max_h", 32'(max_h), 14);
        check("frame_max_v", 32'(max_v), 7);

        // Held at the frame wrap point with ce=0: no strobe until ce returns
        check("wrap_pre_h", 32'(hcount_s), 14);
        check("wrap_pre_v", 32'(vcount_s), 7);
        ce_s = 1'b0;
        tick(1); check("wrap_ce0_fs_a", 32'(fs_s), 0); check("wrap_ce0_h_a", 32'(hcount_s), 14);
        tick(1); check("wrap_ce0_fs_b", 32'(fs_s), 0); check("wrap_ce0_h_b", 32'(hcount_s), 14);
        ce_s = 1'b1;
        tick(1);
        check("wrap_fs", 32'(fs_s), 1);
        check("wrap_h", 32'(hcount_s), 0);
        check("wrap_v", 32'(vcount_s), 0);
        tick(1);
        check("wrap_fs_one_cycle", 32'(fs_s), 0);

        // Asynchronous reset while both syncs are low (h=11, v=6)
        tick(100);
        check("both_sync_h", 32'(hcount_s), 11);
        check("both_sync_v", 32'(vcount_s), 6);
        check("both_sync_hs", 32'(hs_s), 0);
        check("both_sync_vs", 32'(vs_s), 0);
        #3 rst_s = 1'b1;
        #1;
        check("sarst_h", 32'(hcount_s), 0);
        check("sarst_v", 32'(vcount_s), 0);
        check("sarst_hs", 32'(hs_s), 1);
        check("sarst_vs", 32'(vs_s), 1);
        check("sarst_blank", 32'(blank_s), 0);
        check("sarst_fs", 32'(fs_s), 0);
        tick(1);
        rst_s = 1'b0;
        tick(1);
        check("sarst_resume_h", 32'(hcount_s), 1);
        check("sarst_resume_fs", 32'(fs_s), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
